// File: rtl/csl_add_sub_pipe.sv
// csl_add_sub_pipe
// Pipelined carry-select adder/subtractor with a valid/ready handshake.
// The operand word is cut into BLOCK-bit carry-select blocks. Each block
// forms its sum for carry-in 0 and for carry-in 1 in parallel. The real
// block carry then picks one of the two. The block chain is spread over
// STAGES register stages at block boundaries, and the partial sum and
// carry are registered between stages. Flags are derived from the
// full-width result in the last stage and registered alongside it.
// Flow control is a stall-all shift chain: every stage advances together
// whenever the output register is empty or being drained.

module csl_add_sub_pipe #(
  parameter int WIDTH  = 23,  // operand/result width, >= 2
  parameter int BLOCK  = 4,   // carry-select block width
  parameter int STAGES = 2    // register stages, 1..4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NBLK = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int LAST = STAGES - 1;

  // Everything a beat needs on its way down the chain. The operands stay
  // in the beat so that later stages can finish the upper blocks.
  typedef struct packed {
    logic [WIDTH-1:0] a;    // operand A
    logic [WIDTH-1:0] b;    // operand B, already inverted for subtraction
    logic [WIDTH-1:0] sum;  // result bits of the blocks already resolved
    logic             c;    // carry into the first unresolved block
  } beat_t;

  // First block handled by stage s. Stage s owns blocks
  // [blk_lo(s), blk_lo(s+1)), which spreads the blocks as evenly as the
  // division allows. blk_lo(STAGES) equals NBLK.
  function automatic int blk_lo(input int s);
    return (s * NBLK) / STAGES;
  endfunction

  // Stage that owns block k. If STAGES exceeds NBLK, some stages own no
  // block and only pass the beat along.
  function automatic int stage_of(input int k);
    int r;
    r = 0;
    for (int s = 0; s < STAGES; s++) begin
      if (blk_lo(s) <= k) r = s;
    end
    return r;
  endfunction

  // Mask that covers every result bit of blocks 0 .. nblk-1.
  function automatic logic [WIDTH-1:0] low_mask(input int nblk);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < nblk * BLOCK) m[i] = 1'b1;
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------
  logic              adv;
  logic [STAGES-1:0] vld;  // vld[s]: the register after stage s holds a beat

  assign out_valid = vld[LAST];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Shift the valid bits along the chain on every advance. An idle input
  // enters as a bubble. Reset empties every stage.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments, so
    // every stage samples its neighbour's pre-edge value and the shift
    // works regardless of statement order.
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld <= (vld << 1) | STAGES'(in_valid);
    end
  end

  // ---------------------------------------------------------------------
  // Stage inputs: stage 0 is fed from the ports, and each later stage is
  // fed from the register of the stage before it.
  // ---------------------------------------------------------------------
  beat_t            st_in  [STAGES];
  logic [WIDTH-1:0] st_sum [STAGES];
  logic             st_c   [STAGES];

  // Subtraction is A + ~B + 1. The +1 enters as the carry into block 0.
  assign st_in[0] = '{a: a, b: (sub ? ~b : b), sum: '0, c: sub};

  // ---------------------------------------------------------------------
  // Carry-select blocks. Each block reads the stage input of the stage
  // that owns it. blk_sum holds every block's selected sum; a stage only
  // keeps the bits of its own blocks.
  // ---------------------------------------------------------------------
  wire [WIDTH-1:0] blk_sum;
  wire [NBLK-1:0]  blk_c;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LSB = k * BLOCK;
    localparam int BW  = (WIDTH - LSB < BLOCK) ? (WIDTH - LSB) : BLOCK;
    localparam int SK  = stage_of(k);

    logic [BW:0] sum0;  // {carry, sum} for carry-in 0
    logic [BW:0] sum1;  // {carry, sum} for carry-in 1
    logic        cin;

    assign sum0 = {1'b0, st_in[SK].a[LSB +: BW]} + {1'b0, st_in[SK].b[LSB +: BW]};
    assign sum1 = {1'b0, st_in[SK].a[LSB +: BW]} + {1'b0, st_in[SK].b[LSB +: BW]}
                + {{BW{1'b0}}, 1'b1};

    // The first block of a stage takes the carry registered by the
    // previous stage. Any other block takes the carry of the block below.
    if (blk_lo(SK) == k) begin : g_first
      assign cin = st_in[SK].c;
    end else begin : g_chain
      assign cin = blk_c[k-1];
    end

    assign blk_sum[LSB +: BW] = cin ? sum1[BW-1:0] : sum0[BW-1:0];
    assign blk_c[k]           = cin ? sum1[BW]     : sum0[BW];
  end

  // ---------------------------------------------------------------------
  // Stages: merge this stage's blocks into the partial sum, pass the
  // carry on, and register the beat unless this is the last stage.
  // ---------------------------------------------------------------------
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = blk_lo(s);
    localparam int HI = blk_lo(s + 1);
    localparam logic [WIDTH-1:0] DONE_M = low_mask(LO);
    localparam logic [WIDTH-1:0] OWN_M  = low_mask(HI) & ~low_mask(LO);

    assign st_sum[s] = (st_in[s].sum & DONE_M) | (blk_sum & OWN_M);

    if (HI > LO) begin : g_cout
      assign st_c[s] = blk_c[HI-1];
    end else begin : g_pass
      assign st_c[s] = st_in[s].c;
    end

    if (s < LAST) begin : g_reg
      beat_t q;

      // Capture the partially resolved beat whenever the chain advances.
      always_ff @(posedge clk) begin
        // NOTE: datapath registers have no reset; the matching valid bit
        // decides whether their contents mean anything, and that bit is
        // cleared by reset.
        if (adv) begin
          q <= '{a: st_in[s].a, b: st_in[s].b, sum: st_sum[s], c: st_c[s]};
        end
      end

      assign st_in[s+1] = q;
    end
  end

  // ---------------------------------------------------------------------
  // Output stage: the result is complete at the last stage. Derive the
  // flags from the full-width result and register them with it.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] res_n;
  logic             cout_n;
  logic             ovf_n;
  logic             zero_n;

  assign res_n  = st_sum[LAST];
  assign cout_n = st_c[LAST];
  // Signed overflow: the effective operands have the same sign and the
  // result sign differs from it.
  assign ovf_n  = (st_in[LAST].a[WIDTH-1] == st_in[LAST].b[WIDTH-1])
               && (res_n[WIDTH-1] != st_in[LAST].a[WIDTH-1]);
  assign zero_n = (res_n == '0);

  // Load the output register on every advance and hold it while the
  // consumer stalls. Reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (adv) begin
      result <= res_n;
      cout   <= cout_n;
      ovf    <= ovf_n;
      zero   <= zero_n;
    end
  end

endmodule

// File: tb/tb_csl_add_sub_pipe.sv
// tb_csl_add_sub_pipe
// Scoreboard bench for csl_add_sub_pipe. Drivers push the expected
// response when a beat is accepted. Per-DUT monitors pop and compare
// whenever a result beat is delivered. The main instance (23/4/2) gets
// directed cases plus a random stream. Two extra instances (8/3/1 and
// 32/5/4) get random streams only.

module tb_csl_add_sub_pipe;

  typedef struct packed {
    logic [63:0] res;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  localparam int W0 = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rnd_go = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [63:0] r, input logic c, input logic o, input logic zz);
    exp_t e;
    e.res = r; e.co = c; e.ov = o; e.z = zz;
    return e;
  endfunction

  // Reference model: plain integer arithmetic on the unsigned and signed
  // readings of the operands.
  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic s);
    longint full, m, half, ua, ub, sa, sb, t, r;
    exp_t e;
    full = longint'(1) << w;
    m    = full - 1;
    half = full / 2;
    ua   = longint'(x) & m;
    ub   = longint'(y) & m;
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    r    = s ? ((ua - ub) & m) : ((ua + ub) & m);
    t    = s ? (sa - sb) : (sa + sb);
    e.res = 64'(r);
    e.co  = s ? (ua >= ub) : ((ua + ub) > m);
    e.ov  = (t >= half) || (t < -half);
    e.z   = (r == 0);
    return e;
  endfunction

  // Random operand with a bias toward the edge values that exercise the
  // carry and overflow flags.
  function automatic logic [63:0] pick(input int w);
    logic [63:0] full, m;
    full = 64'd1 << w;
    m    = full - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return m;
      2:       return full >> 1;
      3:       return (full >> 1) - 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // -----------------------------------------------------------------------
  // Main instance
  // -----------------------------------------------------------------------
  logic          in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1, sub0 = 1'b0;
  logic          cout0, ovf0, zero0;
  logic [W0-1:0] a0 = '0, b0 = '0, result0;
  exp_t          q0[$];

  csl_add_sub_pipe #(.WIDTH(W0), .BLOCK(4), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0),
    .result(result0), .cout(cout0), .ovf(ovf0), .zero(zero0)
  );

  // Monitor: compare every delivered beat against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        check("w23 spurious out_valid", 64'(out_valid0), 64'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("w23 result", 64'(result0), e.res);
        check("w23 cout", 64'(cout0), 64'(e.co));
        check("w23 ovf", 64'(ovf0), 64'(e.ov));
        check("w23 zero", 64'(zero0), 64'(e.z));
      end
    end
  end

  // One cycle: drive inputs, then sample the handshake mid-cycle.
  task automatic step0(input logic v, input logic [63:0] x, input logic [63:0] y, input logic s,
                       input logic rdy, input exp_t e, output logic acc);
    in_valid0 = v; a0 = x[W0-1:0]; b0 = y[W0-1:0]; sub0 = s; out_ready0 = rdy;
    @(negedge clk);
    acc = !rst && in_valid0 && in_ready0;
    if (acc) q0.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic send0(input logic [63:0] x, input logic [63:0] y, input logic s,
                       input logic rdy, input exp_t e);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      step0(1'b1, x, y, s, rdy, e, acc);
      n++;
    end
    check("w23 beat accepted", 64'(acc), 64'd1);
  endtask

  // Count edges from the accepting edge until out_valid rises.
  task automatic latency0(input string name);
    int n;
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    n = 1;
    while (!out_valid0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(n), 64'd2);
  endtask

  task automatic drain0();
    int n;
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    n = 0;
    while (q0.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("w23 drained", 64'(q0.size()), 64'd0);
  endtask

  // -----------------------------------------------------------------------
  // Extra configurations, random traffic only
  // -----------------------------------------------------------------------
  for (genvar g = 1; g < 3; g++) begin : g_x
    localparam int W = (g == 1) ? 8 : 32;
    localparam int B = (g == 1) ? 3 : 5;
    localparam int S = (g == 1) ? 1 : 4;

    logic         iv, ir, ovld, ordy, sb, co, of, zr, done;
    logic [W-1:0] xa, xb, r;
    exp_t         q[$];

    csl_add_sub_pipe #(.WIDTH(W), .BLOCK(B), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
      .a(xa), .b(xb), .sub(sb), .out_valid(ovld), .out_ready(ordy),
      .result(r), .cout(co), .ovf(of), .zero(zr)
    );

    always @(negedge clk) begin
      if (!rst && ovld && ordy) begin
        if (q.size() == 0) begin
          check($sformatf("w%0d s%0d spurious out_valid", W, S), 64'(ovld), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("w%0d s%0d result", W, S), 64'(r), e.res);
          check($sformatf("w%0d s%0d cout", W, S), 64'(co), 64'(e.co));
          check($sformatf("w%0d s%0d ovf", W, S), 64'(of), 64'(e.ov));
          check($sformatf("w%0d s%0d zero", W, S), 64'(zr), 64'(e.z));
        end
      end
    end

    initial begin
      int          acc_n, cyc;
      logic [63:0] x, y;
      logic        s;
      iv = 1'b0; ordy = 1'b1; sb = 1'b0; xa = '0; xb = '0; done = 1'b0;
      wait (rnd_go);
      @(posedge clk); #1;
      acc_n = 0;
      cyc = 0;
      while (acc_n < 1000 && cyc < 8000) begin
        x = pick(W); y = pick(W); s = 1'(($urandom & 1));
        iv = ($urandom_range(0, 3) != 0); xa = x[W-1:0]; xb = y[W-1:0]; sb = s;
        ordy = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (!rst && iv && ir) begin
          q.push_back(model(W, x, y, s));
          acc_n++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("w%0d s%0d beats accepted", W, S), 64'(acc_n), 64'd1000);
      iv = 1'b0; ordy = 1'b1;
      cyc = 0;
      while (q.size() != 0 && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("w%0d s%0d drained", W, S), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
  end

  // -----------------------------------------------------------------------
  // Main sequence
  // -----------------------------------------------------------------------
  initial begin
    logic        acc;
    logic [63:0] x, y;
    logic        s;
    int          n;

    // Reset state, observed in the first cycle after reset.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", 64'(out_valid0), 64'd0);
    check("reset in_ready", 64'(in_ready0), 64'd1);
    check("reset result", 64'(result0), 64'd0);
    check("reset cout", 64'(cout0), 64'd0);
    check("reset ovf", 64'(ovf0), 64'd0);
    check("reset zero", 64'(zero0), 64'd0);
    @(posedge clk); #1;

    // Plain add and its latency.
    send0(64'd255, 64'd254, 1'b0, 1'b1, mk(64'd509, 1'b0, 1'b0, 1'b0));
    latency0("w23 latency");
    drain0();

    // Back-to-back add/sub mix: borrow, wrap-around, signed overflow, zero.
    send0(64'd255, 64'd254, 1'b1, 1'b1, mk(64'd1, 1'b1, 1'b0, 1'b0));
    send0(64'd1, 64'd16, 1'b1, 1'b1, mk(64'h7FFFF1, 1'b0, 1'b0, 1'b0));
    send0(64'h3FFFFF, 64'd1, 1'b0, 1'b1, mk(64'h400000, 1'b0, 1'b1, 1'b0));
    send0(64'h400000, 64'd1, 1'b1, 1'b1, mk(64'h3FFFFF, 1'b1, 1'b1, 1'b0));
    send0(64'h12345, 64'h12345, 1'b1, 1'b1, mk(64'd0, 1'b1, 1'b0, 1'b1));
    send0(64'h7FFFFF, 64'h7FFFFF, 1'b0, 1'b1, mk(64'h7FFFFE, 1'b1, 1'b0, 1'b0));
    drain0();

    // Stall: two beats fill the pipe, the third waits while out_ready=0.
    send0(64'd100, 64'd50, 1'b0, 1'b0, mk(64'd150, 1'b0, 1'b0, 1'b0));
    send0(64'd100, 64'd50, 1'b1, 1'b0, mk(64'd50, 1'b1, 1'b0, 1'b0));
    in_valid0 = 1'b1; a0 = 23'h7FFFFF; b0 = 23'd1; sub0 = 1'b0; out_ready0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall in_ready", 64'(in_ready0), 64'd0);
      check("stall out_valid", 64'(out_valid0), 64'd1);
      check("stall result held", 64'(result0), 64'd150);
      check("stall cout held", 64'(cout0), 64'd0);
      @(posedge clk); #1;
    end
    send0(64'h7FFFFF, 64'd1, 1'b0, 1'b1, mk(64'd0, 1'b1, 1'b0, 1'b1));
    drain0();

    // Reset with two beats in flight: both vanish, and the next beat
    // emerges with normal latency.
    send0(64'd1, 64'd2, 1'b0, 1'b1, mk(64'd3, 1'b0, 1'b0, 1'b0));
    send0(64'd5, 64'd3, 1'b1, 1'b1, mk(64'd2, 1'b1, 1'b0, 1'b0));
    rst = 1'b1; in_valid0 = 1'b0; out_ready0 = 1'b1;
    @(negedge clk);
    q0.delete();
    @(posedge clk); #1;
    check("flush out_valid", 64'(out_valid0), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("flush stays idle", 64'(out_valid0), 64'd0);
    end
    send0(64'd7, 64'd8, 1'b0, 1'b1, mk(64'd15, 1'b0, 1'b0, 1'b0));
    latency0("post-reset latency");
    drain0();

    // Random traffic on every instance.
    rnd_go = 1'b1;
    n = 0;
    begin
      int acc_n;
      acc_n = 0;
      while (acc_n < 1000 && n < 8000) begin
        x = pick(W0); y = pick(W0); s = 1'(($urandom & 1));
        step0(($urandom_range(0, 3) != 0), x, y, s, ($urandom_range(0, 3) != 0),
              model(W0, x, y, s), acc);
        if (acc) acc_n++;
        n++;
      end
      check("w23 beats accepted", 64'(acc_n), 64'd1000);
    end
    drain0();

    n = 0;
    while (!(g_x[1].done && g_x[2].done) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("extra configs finished", 64'(g_x[1].done && g_x[2].done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
